// File: rtl/data_mem_wait.sv
// Word-addressed data memory with a valid/ready request port, configurable wait
// states, byte-enable stores, out-of-range detection and an optional post-reset clear sweep.
module data_mem_wait #(
    parameter int DEPTH          = 256,
    parameter int DATA_W         = 32,
    parameter int WAIT           = 0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              BE_W      = DATA_W / 8;
    localparam logic [7:0]      WAIT_LAST = (WAIT > 0) ? 8'(WAIT - 1) : 8'd0;
    localparam logic [AW-1:0]   PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [31:0]     DEPTH_W   = 32'(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     clr_ptr;
    logic [7:0]        wait_cnt;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic              accept;
    logic              in_range;
    logic [AW-1:0]     lat_idx;
    logic              ready_nxt;
    logic              busy_nxt;

    assign accept   = (state == ST_IDLE) && req_valid && req_ready;
    assign in_range = (lat_addr < DEPTH_W);
    assign lat_idx  = lat_addr[AW-1:0];

    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        busy_nxt  = 1'b1;
        case (state)
            ST_CLEAR: if (clr_ptr == PTR_LAST) state_nxt = ST_IDLE;
            ST_IDLE:  if (accept) state_nxt = (WAIT > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt  = (state_nxt != ST_IDLE);
    end

    // Response outputs are produced from the RESP state, so they appear one edge after it is entered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_ptr   <= '0;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= ready_nxt;
            busy      <= busy_nxt;
            rsp_valid <= (state == ST_RESP);
            rsp_err   <= (state == ST_RESP) && !in_range;
            rsp_rdata <= ((state == ST_RESP) && !lat_we && in_range) ? mem[lat_idx] : '0;
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            wait_cnt  <= (state == ST_WAIT) ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // A reset in flight suppresses the commit, so a dropped store never reaches the array
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if ((state == ST_RESP) && lat_we && in_range) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (lat_be[k]) begin
                        mem[lat_idx][8*k +: 8] <= lat_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_wait.sv
// Directed bench for data_mem_wait: one zero-wait instance with clear sweep and one
// eight-wait instance without, checked with immediate assertions.
module tb_data_mem_wait;

    logic        clk;
    logic [1:0]  reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_be;

    logic        ready0, ready1, valid0, valid1, err0, err1, busy0, busy1;
    logic [31:0] rdata0, rdata1;

    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_err;
    logic [1:0]       busy;
    logic [1:0][31:0] rsp_rdata;

    assign req_ready = {ready1, ready0};
    assign rsp_valid = {valid1, valid0};
    assign rsp_err   = {err1, err0};
    assign busy      = {busy1, busy0};
    assign rsp_rdata = {rdata1, rdata0};

    int compared   = 0;
    int mismatched = 0;

    data_mem_wait #(.DEPTH(256), .DATA_W(32), .WAIT(0), .CLEAR_ON_RESET(1'b1)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(ready0), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(valid0), .rsp_rdata(rdata0), .rsp_err(err0), .busy(busy0)
    );

    data_mem_wait #(.DEPTH(256), .DATA_W(32), .WAIT(8), .CLEAR_ON_RESET(1'b0)) dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(ready1), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(valid1), .rsp_rdata(rdata1), .rsp_err(err1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitReady(input int sel, output int n);
        n = 0;
        while (!req_ready[sel] && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issueRequest(input int sel, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
        int n;
        waitReady(sel, n);
        if (!req_ready[sel]) checkOutput("ready_timeout", {31'd0, req_ready[sel]}, 32'd1);
        req_valid[sel] = 1'b1;
        req_we[sel]    = we;
        req_addr[sel]  = addr;
        req_wdata[sel] = wdata;
        req_be[sel]    = be;
        @(posedge clk);
        @(negedge clk);
        req_valid[sel] = 1'b0;
    endtask

    // Full transaction: latency counted in negedges after the accept edge
    task automatic applyStimulus(input string tag, input int sel, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [31:0] exp_rdata,
                                 input logic exp_err);
        int lat;
        issueRequest(sel, we, addr, wdata, be);
        lat = 0;
        while (!rsp_valid[sel] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_lat"}, 32'(lat), (sel == 0) ? 32'd1 : 32'd9);
        checkOutput({tag, "_rdata"}, rsp_rdata[sel], exp_rdata);
        checkOutput({tag, "_err"}, {31'd0, rsp_err[sel]}, {31'd0, exp_err});
        @(negedge clk);
        checkOutput({tag, "_pulse"}, {31'd0, rsp_valid[sel]}, 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        int seen;
        reset     = 2'b00;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_ready", {31'd0, req_ready[0]}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy[0]}, 32'd1);
        checkOutput("rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
        checkOutput("rst_rdata", rsp_rdata[0], 32'd0);
        checkOutput("rst_err", {31'd0, rsp_err[0]}, 32'd0);
        reset = 2'b11;
        waitReady(0, n);
        checkOutput("clear_edges", 32'(n), 32'd256);
        checkOutput("idle_busy", {31'd0, busy[0]}, 32'd0);

        applyStimulus("sw3", 0, 1'b1, 32'd3, 32'd7, 4'hF, 32'd0, 1'b0);
        applyStimulus("lw3", 0, 1'b0, 32'd3, 32'd0, 4'h0, 32'd7, 1'b0);
        applyStimulus("lw10_cleared", 0, 1'b0, 32'd10, 32'd0, 4'h0, 32'd0, 1'b0);

        applyStimulus("sw5_full", 0, 1'b1, 32'd5, 32'hAABBCCDD, 4'hF, 32'd0, 1'b0);
        applyStimulus("sw5_byte1", 0, 1'b1, 32'd5, 32'h00001100, 4'h2, 32'd0, 1'b0);
        applyStimulus("lw5_merge", 0, 1'b0, 32'd5, 32'd0, 4'h0, 32'hAABB11DD, 1'b0);
        applyStimulus("sw5_be0", 0, 1'b1, 32'd5, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
        applyStimulus("lw5_be0", 0, 1'b0, 32'd5, 32'd0, 4'h0, 32'hAABB11DD, 1'b0);

        applyStimulus("sw256_oor", 0, 1'b1, 32'd256, 32'h12345678, 4'hF, 32'd0, 1'b1);
        applyStimulus("lw0_nowrap", 0, 1'b0, 32'd0, 32'd0, 4'h0, 32'd0, 1'b0);
        applyStimulus("lw_high_oor", 0, 1'b0, 32'h100000FF, 32'd0, 4'h0, 32'd0, 1'b1);
        applyStimulus("sw255", 0, 1'b1, 32'd255, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b0);
        applyStimulus("lw255", 0, 1'b0, 32'd255, 32'd0, 4'h0, 32'hFFFFFFFF, 1'b0);

        reset[0] = 1'b0;
        @(negedge clk);
        reset[0] = 1'b1;
        checkOutput("rst2_busy", {31'd0, busy[0]}, 32'd1);
        waitReady(0, n);
        checkOutput("reclear_edges", 32'(n), 32'd256);
        applyStimulus("lw255_cleared", 0, 1'b0, 32'd255, 32'd0, 4'h0, 32'd0, 1'b0);

        applyStimulus("w8_sw3", 1, 1'b1, 32'd3, 32'd7, 4'hF, 32'd0, 1'b0);
        issueRequest(1, 1'b0, 32'd3, 32'd0, 4'h0);
        checkOutput("w8_busy", {31'd0, busy[1]}, 32'd1);
        bad = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) bad++;
        end
        checkOutput("w8_quiet_cycles", 32'(bad), 32'd0);
        @(negedge clk);
        checkOutput("w8_valid", {31'd0, rsp_valid[1]}, 32'd1);
        checkOutput("w8_ready", {31'd0, req_ready[1]}, 32'd1);
        checkOutput("w8_rdata", rsp_rdata[1], 32'd7);
        @(negedge clk);
        checkOutput("w8_pulse", {31'd0, rsp_valid[1]}, 32'd0);

        issueRequest(1, 1'b1, 32'd3, 32'd9, 4'hF);
        repeat (3) @(negedge clk);
        reset[1] = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready", {31'd0, req_ready[1]}, 32'd0);
        reset[1] = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen++;
        end
        checkOutput("midrst_no_rsp", 32'(seen), 32'd0);
        applyStimulus("midrst_lw3", 1, 1'b0, 32'd3, 32'd0, 4'h0, 32'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
